// File: rtl/vga_video_tx.sv
// VGA-style video transmitter: pixel divider, h/v counters, and registered sync/colour outputs.
// Colour and both syncs are loaded on the same pixel-enable edge, so they leave the block aligned.
module vga_video_tx #(
    parameter int   H_DISPLAY = 256,
    parameter int   H_FRONT   = 7,
    parameter int   H_SYNC    = 23,
    parameter int   H_BACK    = 23,
    parameter int   V_DISPLAY = 240,
    parameter int   V_BOTTOM  = 14,
    parameter int   V_SYNC    = 3,
    parameter int   V_TOP     = 5,
    parameter int   CLK_DIV   = 2,
    parameter logic SYNC_POL  = 1'b0,
    parameter int   FCNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        pix_rgb,
    output logic [8:0]        hpos,
    output logic [8:0]        vpos,
    output logic              pix_req,
    output logic              hsync,
    output logic              vsync,
    output logic [2:0]        rgb,
    output logic              frame_start,
    output logic [FCNT_W-1:0] frame_cnt
);

    localparam int H_TOTAL   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL   = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP;
    localparam int HS_FIRST  = H_DISPLAY + H_FRONT;
    localparam int HS_LAST   = H_DISPLAY + H_FRONT + H_SYNC - 1;
    localparam int VS_FIRST  = V_DISPLAY + V_BOTTOM;
    localparam int VS_LAST   = V_DISPLAY + V_BOTTOM + V_SYNC - 1;

    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic [8:0] H_LAST   = 9'(H_TOTAL - 1);
    localparam logic [8:0] V_LAST   = 9'(V_TOTAL - 1);

    // Counter widths are fixed at 9 bits, so oversized timings must be rejected outright.
    if (H_TOTAL > 512 || V_TOTAL > 512) begin : g_bad_total
        $error("vga_video_tx: H_TOTAL/V_TOTAL exceed the 9-bit hpos/vpos range");
    end
    if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
        $error("vga_video_tx: CLK_DIV must be in 1..16");
    end

    logic [3:0] div_cnt;
    logic       pix_en;
    logic       display;
    logic       h_act;
    logic       v_act;

    always_comb begin
        pix_en  = reset && (div_cnt == 4'd0);
        display = (hpos < 9'(H_DISPLAY)) && (vpos < 9'(V_DISPLAY));
        h_act   = (hpos >= 9'(HS_FIRST)) && (hpos <= 9'(HS_LAST));
        v_act   = (vpos >= 9'(VS_FIRST)) && (vpos <= 9'(VS_LAST));
        pix_req = pix_en && display;
    end

    // Everything below moves only on pix_en; frame_start is a single-clk pulse
    // raised on the edge that launches pixel (0,0).
    always_ff @(posedge clk) begin
        if (!reset) begin
            div_cnt     <= 4'd0;
            hpos        <= 9'd0;
            vpos        <= 9'd0;
            rgb         <= 3'd0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            div_cnt     <= (div_cnt == DIV_LAST) ? 4'd0 : div_cnt + 4'd1;
            frame_start <= 1'b0;
            if (pix_en) begin
                if (hpos == H_LAST) begin
                    hpos <= 9'd0;
                    vpos <= (vpos == V_LAST) ? 9'd0 : vpos + 9'd1;
                end else begin
                    hpos <= hpos + 9'd1;
                end
                rgb   <= display ? pix_rgb : 3'd0;
                hsync <= h_act ? SYNC_POL : ~SYNC_POL;
                vsync <= v_act ? SYNC_POL : ~SYNC_POL;
                if (hpos == 9'd0 && vpos == 9'd0) begin
                    frame_start <= 1'b1;
                    frame_cnt   <= frame_cnt + FCNT_W'(1);
                end
            end
        end
    end

endmodule
